alp_param: RTL
==============

# alp_param

Parametrised successor to the 4-bit two-register arithmetic logic processor. It holds a DEPTH-entry register file of WIDTH-bit registers, loaded sequentially from a data input. It executes eight operations between any two registers into any destination, using a small control FSM. Single-cycle ALU ops and a multi-cycle shift-add multiplier share one busy/done handshake. An error flag reports overflow, borrow, multiply truncation and register-file overflow. The block sits where the fixed ALP sat, behind the same switch-style LOAD/CLR/COMP controls.

## Interface
Parameters:
- WIDTH, 4, data and register width (≥2)
- DEPTH, 4, number of registers (power of 2, ≥2); AW = log2(DEPTH)

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- i_DATA_IN  in  WIDTH  load data
- i_OP  in  3  opcode: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR, 5 SHL, 6 SHR, 7 MUL
- i_SRC_A, i_SRC_B, i_DST  in  AW  operand and destination register indices
- i_LOAD  in  1  write i_DATA_IN to the register at the load pointer
- i_CLR  in  1  synchronous clear of registers, pointer, ERR; aborts any operation
- i_COMP  in  1  start operation i_OP
- i_RADDR  in  AW  read address
- o_RDATA  out  WIDTH  reg[i_RADDR], combinational
- o_R0, o_R1  out  WIDTH  reg[0], reg[1], direct
- o_BUSY  out  1  operation in progress
- o_DONE  out  1  one-cycle pulse after result write
- o_ERR  out  1  error flag

## Operation
- Reset or CLR: all registers 0, load pointer 0, load count 0, o_ERR 0, o_DONE 0, o_BUSY 0, FSM in IDLE.
- FSM states: IDLE, EXEC, MUL, DONE.
- Command priority in IDLE: CLR > LOAD > COMP.
- In EXEC, MUL and DONE, LOAD and COMP are ignored. CLR is always honoured and returns the FSM to IDLE with no DONE pulse.
- LOAD, when count < DEPTH: reg[ptr] ← i_DATA_IN; ptr ← ptr+1 (wraps mod DEPTH); count+1.
- LOAD, when count = DEPTH: the write is dropped and o_ERR ← 1.
- COMP accepted in IDLE:
  - latches A = reg[i_SRC_A], B = reg[i_SRC_B], the op, and i_DST.
  - goes to MUL if op = 7, else to EXEC.
  - Registers are not changed on acceptance.
- EXEC: result computed from the latched operands and written to reg[DST]. Next state DONE.
- MUL: shift-add over the latched operands, one multiplier bit per cycle, for WIDTH cycles. The 2·WIDTH product forms internally. The low WIDTH bits are written to reg[DST] at the end of the last cycle. Next state DONE.
- DONE: o_DONE = 1 for one cycle. Next state IDLE.
- Arithmetic rules:
  - ADD: (WIDTH+1)-bit sum; the carry-out is the error bit.
  - SUB: A−B mod 2^WIDTH; the error bit is the borrow (A < B).
  - AND, OR, XOR: bitwise; error bit 0.
  - SHL, SHR: logical shift of A by B. If B ≥ WIDTH the result is 0. Error bit 0.
  - MUL: the error bit is 1 when the product's high WIDTH bits are nonzero.
- o_ERR is written with the completing operation's error bit at the same edge as the result write. It then stays until the next completed operation, a CLR, or reset.
- A load overflow also sets o_ERR.
- SRC = DST is legal; the operands were latched at acceptance.

## Timing
- COMP sampled at edge N. o_BUSY is high from edge N until the edge that enters DONE.
- Non-MUL: EXEC occupies cycle N+1. The write happens at the end of N+1. o_DONE is high in cycle N+2. The next COMP can be accepted at the end of N+2.
- MUL: MUL occupies cycles N+1 .. N+WIDTH. The write happens at the end of N+WIDTH. o_DONE is high in N+WIDTH+1.
- o_R0, o_R1 and o_RDATA reflect a write in the cycle after the write edge.
- LOAD takes effect at the edge where it is sampled. Back-to-back LOADs fill consecutive registers.
- Asynchronous reset mid-operation clears all state immediately. No write and no DONE pulse occur.

## Test plan
- Assert reset with inputs toggling -> all outputs 0. Release reset, LOAD 6 then 9 -> o_R0=6, o_R1=9.
- COMP ADD, A=0, B=1, DST=2 -> o_BUSY high for one cycle; reg2=15; o_ERR=0; o_DONE in cycle N+2. Then COMP ADD, A=1, B=1, DST=3 -> reg3=2, o_ERR=1.
- COMP SUB, A=0 (6), B=1 (9) -> result 13, o_ERR=1. Then SUB, A=1, B=0 -> 3, o_ERR=0. Then SHR, A=1 (9), B holding 5 -> 0.
- With reg0=3, reg1=5: COMP MUL -> o_BUSY high for 4 cycles; DST=15; o_ERR=0; o_DONE in N+5. With reg0=14, reg1=5: MUL -> 6 (70=0x46), o_ERR=1.
- After CLR, LOAD 1, 2, 3, 4, 5 -> registers hold 1..4; the 5th LOAD is dropped; o_ERR=1. CLR -> all registers 0, o_ERR=0.
- Mid-MUL: assert CLR at cycle N+2 -> no write, no o_DONE, o_BUSY low next cycle. Repeat the test with async reset instead -> outputs clear immediately.

Source files
------------

// File: rtl/alp_param.sv
`default_nettype none
// ============================================================================
// Module   : alp_param
// Purpose  : Parametrised arithmetic logic processor. A DEPTH x WIDTH register
//            file is loaded sequentially from i_DATA_IN. Eight operations run
//            between any two registers into any destination. Single-cycle ALU
//            ops and a WIDTH-cycle shift-add multiplier share one busy/done
//            handshake. o_ERR flags carry, borrow, multiply truncation and
//            register-file overflow.
// Revision : 1.0 - initial release
// ============================================================================
module alp_param #(
    parameter int WIDTH = 4,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         i_DATA_IN,
    input  logic [2:0]               i_OP,
    input  logic [$clog2(DEPTH)-1:0] i_SRC_A,
    input  logic [$clog2(DEPTH)-1:0] i_SRC_B,
    input  logic [$clog2(DEPTH)-1:0] i_DST,
    input  logic                     i_LOAD,
    input  logic                     i_CLR,
    input  logic                     i_COMP,
    input  logic [$clog2(DEPTH)-1:0] i_RADDR,
    output logic [WIDTH-1:0]         o_RDATA,
    output logic [WIDTH-1:0]         o_R0,
    output logic [WIDTH-1:0]         o_R1,
    output logic                     o_BUSY,
    output logic                     o_DONE,
    output logic                     o_ERR
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(WIDTH);

    // Load count at which the register file is considered full
    localparam logic [c_AW:0]   c_FULL     = (c_AW + 1)'(DEPTH);
    // Multiplier step counter value of the final partial-product cycle
    localparam logic [c_CW-1:0] c_MUL_LAST = c_CW'(WIDTH - 1);

    localparam logic [2:0] c_OP_ADD = 3'd0;
    localparam logic [2:0] c_OP_SUB = 3'd1;
    localparam logic [2:0] c_OP_AND = 3'd2;
    localparam logic [2:0] c_OP_OR  = 3'd3;
    localparam logic [2:0] c_OP_XOR = 3'd4;
    localparam logic [2:0] c_OP_SHL = 3'd5;
    localparam logic [2:0] c_OP_SHR = 3'd6;
    localparam logic [2:0] c_OP_MUL = 3'd7;

    localparam logic [1:0] c_S_IDLE = 2'd0;
    localparam logic [1:0] c_S_EXEC = 2'd1;
    localparam logic [1:0] c_S_MUL  = 2'd2;
    localparam logic [1:0] c_S_DONE = 2'd3;

    logic [WIDTH-1:0]   r_regs [DEPTH];
    logic [c_AW-1:0]    r_ptr;
    logic [c_AW:0]      r_cnt;
    logic [1:0]         r_state;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2:0]         r_op;
    logic [c_AW-1:0]    r_dst;
    logic [2*WIDTH-1:0] r_acc;
    logic [2*WIDTH-1:0] r_mcand;
    logic [WIDTH-1:0]   r_mplier;
    logic [c_CW-1:0]    r_mcnt;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [WIDTH:0]     w_sum;
    logic [WIDTH-1:0]   w_alu_res;
    logic               w_alu_err;
    logic [2*WIDTH-1:0] w_mul_next;

    // Single-cycle ALU on the operands latched at acceptance
    always_comb begin
        w_sum     = {1'b0, r_a} + {1'b0, r_b};
        w_alu_res = '0;
        w_alu_err = 1'b0;
        case (r_op)
            c_OP_ADD: begin
                w_alu_res = w_sum[WIDTH-1:0];
                w_alu_err = w_sum[WIDTH];
            end
            c_OP_SUB: begin
                w_alu_res = r_a - r_b;
                w_alu_err = (r_a < r_b);
            end
            c_OP_AND: w_alu_res = r_a & r_b;
            c_OP_OR:  w_alu_res = r_a | r_b;
            c_OP_XOR: w_alu_res = r_a ^ r_b;
            // Logical shifts by an amount >= WIDTH already yield zero
            c_OP_SHL: w_alu_res = r_a << r_b;
            c_OP_SHR: w_alu_res = r_a >> r_b;
            default:  w_alu_res = '0;
        endcase
    end

    // Accumulator after adding the current partial product
    assign w_mul_next = r_acc + (r_mplier[0] ? r_mcand : '0);

    // Control FSM, register file, load pointer, multiplier and flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_state  <= c_S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_dst    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else if (i_CLR) begin
            // Clear aborts any operation in flight without a done pulse
            for (int i = 0; i < DEPTH; i++) r_regs[i] <= '0;
            r_ptr    <= '0;
            r_cnt    <= '0;
            r_state  <= c_S_IDLE;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= '0;
            r_dst    <= '0;
            r_acc    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_mcnt   <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                c_S_IDLE: begin
                    if (i_LOAD) begin
                        if (r_cnt == c_FULL) begin
                            r_err <= 1'b1;
                        end else begin
                            r_regs[r_ptr] <= i_DATA_IN;
                            r_ptr         <= r_ptr + 1'b1;
                            r_cnt         <= r_cnt + 1'b1;
                        end
                    end else if (i_COMP) begin
                        r_a      <= r_regs[i_SRC_A];
                        r_b      <= r_regs[i_SRC_B];
                        r_op     <= i_OP;
                        r_dst    <= i_DST;
                        r_acc    <= '0;
                        r_mcand  <= {{WIDTH{1'b0}}, r_regs[i_SRC_A]};
                        r_mplier <= r_regs[i_SRC_B];
                        r_mcnt   <= '0;
                        r_busy   <= 1'b1;
                        r_state  <= (i_OP == c_OP_MUL) ? c_S_MUL : c_S_EXEC;
                    end
                end
                c_S_EXEC: begin
                    r_regs[r_dst] <= w_alu_res;
                    r_err         <= w_alu_err;
                    r_busy        <= 1'b0;
                    r_done        <= 1'b1;
                    r_state       <= c_S_DONE;
                end
                c_S_MUL: begin
                    if (r_mcnt == c_MUL_LAST) begin
                        // Final partial product folds in; keep the low half
                        r_regs[r_dst] <= w_mul_next[WIDTH-1:0];
                        r_err         <= |w_mul_next[2*WIDTH-1:WIDTH];
                        r_busy        <= 1'b0;
                        r_done        <= 1'b1;
                        r_state       <= c_S_DONE;
                    end else begin
                        r_acc    <= w_mul_next;
                        r_mcand  <= r_mcand << 1;
                        r_mplier <= r_mplier >> 1;
                        r_mcnt   <= r_mcnt + 1'b1;
                    end
                end
                c_S_DONE: begin
                    r_state <= c_S_IDLE;
                end
                default: begin
                    r_state <= c_S_IDLE;
                end
            endcase
        end
    end

    // Direct register views and the combinational read port
    assign o_RDATA = r_regs[i_RADDR];
    assign o_R0    = r_regs[0];
    assign o_R1    = r_regs[1];
    assign o_BUSY  = r_busy;
    assign o_DONE  = r_done;
    assign o_ERR   = r_err;

endmodule
`default_nettype wire
